// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, transmit state encoding and CRC-32 byte step.
// Latency: n/a (declarations only).
// Backpressure: n/a. GMII_TX_PAD_EN adds the PAD state to the encoding.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
`ifdef GMII_TX_PAD_EN
    ST_PAD,
`endif
    ST_FCS,
    ST_IFG
  } tx_state_e;

  // One byte of the reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
    logic [31:0] r;
    r = crc ^ {24'd0, dat};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Payload byte stream into the transmit framer (valid/ready/last).
// Latency: n/a (signal bundle only).
// Backpressure: consumer holds s_ready low when it cannot take a byte.
interface gmii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/eth_crc32_d8.sv
// Byte-parallel Ethernet CRC-32 register with enable and synchronous init.
// Latency: updated CRC visible one clock after the byte is presented.
// Backpressure: none; the register only advances when en is high.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  dat,
  output logic [31:0] crc
);

  logic [31:0] crc_d, crc_q;

  // Init has priority so a new frame always starts from the seed value.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, dat);
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, FCS, inter-frame gap.
// Latency: first 0x55 one clock after s_valid is seen in IDLE; accepted byte on gmii_txd next clock.
// Backpressure: s_ready only in SFD/DATA; an s_valid gap there aborts the frame with an inverted FCS.
// Optional feature macro: GMII_TX_PAD_EN pads short payloads with zeros up to MIN_FRAME.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int MIN_FRAME    = 60
) (
  input  logic                    gmii_tx_clk,
  input  logic                    rst_n,
  gmii_tx_framer_if.slave         s,
  output logic                    gmii_tx_en,
  output logic [7:0]              gmii_txd,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun
);

  tx_state_e   state_d, state_q;
  logic [7:0]  idx_d, idx_q;      // preamble / FCS byte / IFG position
  logic [10:0] cnt_d, cnt_q;      // payload+pad bytes, saturating
  logic        bad_d, bad_q;      // frame aborted: send the inverted FCS
  logic        tx_en_d, tx_en_q;
  logic [7:0]  txd_d, txd_q;
  logic        done_d, done_q;
  logic        urun_d, urun_q;
  logic        crc_init, crc_en, s_rdy;
  logic [7:0]  crc_dat;
  logic [31:0] crc;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  logic [10:0] cnt_inc;

  eth_crc32_d8 u_crc (
    .clk   (gmii_tx_clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .dat   (crc_dat),
    .crc   (crc)
  );

  assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  // Correct FCS is ~crc; an aborted frame sends the raw register instead.
  assign fcs_word = bad_q ? crc : ~crc;
  assign fcs_byte = fcs_word[{idx_q[1:0], 3'b000} +: 8];

`ifndef GMII_TX_PAD_EN
  logic unused_min_frame;
  assign unused_min_frame = ^MIN_FRAME;
`endif

  // Next-state, next wire byte and CRC control for the framing sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    tx_en_d  = tx_en_q;
    txd_d    = txd_q;
    done_d   = 1'b0;
    urun_d   = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_dat  = s.s_data;
    s_rdy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        crc_init = 1'b1;
        tx_en_d  = 1'b0;
        txd_d    = 8'h00;
        if (s.s_valid) begin
          state_d = ST_PREAMBLE;
          idx_d   = 8'd1;
          cnt_d   = '0;
          bad_d   = 1'b0;
          tx_en_d = 1'b1;
          txd_d   = PREAMBLE_BYTE;
        end
      end
      ST_PREAMBLE: begin
        if (idx_q == 8'(PREAMBLE_LEN)) begin
          state_d = ST_SFD;
          txd_d   = SFD_BYTE;
        end else begin
          idx_d   = idx_q + 8'd1;
          txd_d   = PREAMBLE_BYTE;
        end
      end
      ST_SFD, ST_DATA: begin
        s_rdy = 1'b1;
        if (s.s_valid) begin
          txd_d   = s.s_data;
          crc_en  = 1'b1;
          cnt_d   = cnt_inc;
          state_d = ST_DATA;
          if (s.s_last) begin
            idx_d   = 8'd0;
            state_d = ST_FCS;
`ifdef GMII_TX_PAD_EN
            if (cnt_inc < 11'(MIN_FRAME)) state_d = ST_PAD;
`endif
          end
        end else begin
          // Abort: the first inverted FCS byte replaces the missing payload byte.
          urun_d  = 1'b1;
          bad_d   = 1'b1;
          txd_d   = crc[7:0];
          idx_d   = 8'd1;
          state_d = ST_FCS;
        end
      end
`ifdef GMII_TX_PAD_EN
      ST_PAD: begin
        txd_d   = 8'h00;
        crc_en  = 1'b1;
        crc_dat = 8'h00;
        cnt_d   = cnt_inc;
        if (cnt_inc == 11'(MIN_FRAME)) begin
          idx_d   = 8'd0;
          state_d = ST_FCS;
        end
      end
`endif
      ST_FCS: begin
        txd_d = fcs_byte;
        if (idx_q[1:0] == 2'd3) begin
          done_d  = 1'b1;
          idx_d   = 8'd0;
          state_d = ST_IFG;
        end else begin
          idx_d   = idx_q + 8'd1;
        end
      end
      ST_IFG: begin
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        if (idx_q == 8'(IFG_BYTES - 1)) begin
          idx_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered GMII outputs.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      tx_en_q <= 1'b0;
      txd_q   <= '0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  assign s.s_ready  = s_rdy;
  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign underrun   = urun_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: directed frames plus random frames against a byte-level frame model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gmii_tx_framer;

  localparam int PRE  = 7;
  localparam int IFG  = 12;
  localparam int MINF = 60;
`ifdef GMII_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       done;
    logic       ur;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       busy, frame_done, underrun;

  always #4 clk = ~clk;

  gmii_tx_framer_if sif ();

  gmii_tx_framer #(
    .PREAMBLE_LEN (PRE),
    .IFG_BYTES    (IFG),
    .MIN_FRAME    (MINF)
  ) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .s           (sif),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [31:0] crc_tbl [0:255];
  int          last_len = 0;
  int          last_gap = 0;
  int          run = 0;
  bit          prev_en = 1'b0;
  bit          seen = 1'b0;
  bit          start_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame check sequence over a byte list: ~CRC, table-driven.
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[k]) c = crc_tbl[c[7:0] ^ b[k]] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic done, input logic ur);
    exp_t e;
    e.d = d; e.done = done; e.ur = ur;
    return e;
  endfunction

  // Queue the expected wire bytes for a frame of which nsent payload bytes get through.
  task automatic push_frame(input logic [7:0] pl[$], input int nsent, input bit ur, output int elen);
    logic [7:0]  body[$];
    logic [31:0] f;
    for (int k = 0; k < PRE; k++) exp_q.push_back(mk(8'h55, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hD5, 1'b0, 1'b0));
    for (int k = 0; k < nsent; k++) begin
      body.push_back(pl[k]);
      exp_q.push_back(mk(pl[k], 1'b0, 1'b0));
    end
    if (!ur && PAD_EN) begin
      while (body.size() < MINF) begin
        body.push_back(8'h00);
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0));
      end
    end
    f = fcs_of(body);
    if (ur) f = ~f;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(f[8*k +: 8], k == 3, ur && (k == 0)));
    elen = PRE + 1 + body.size() + 4;
  endtask

  // Offer a payload; optionally drop s_valid after drop_after bytes or reset after rst_after bytes.
  task automatic send(input logic [7:0] pl[$], input int drop_after, input int rst_after);
    int   i;
    int   budget;
    logic rdy;
    i = 0;
    budget = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = pl[0];
    sif.s_last  = (pl.size() == 1);
    while (i < pl.size()) begin
      if (i == drop_after) begin
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        break;
      end
      if (i == rst_after) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx_en", gmii_tx_en, 0);
        chk("rst_txd", gmii_txd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", sif.s_ready, 0);
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        return;
      end
      rdy = sif.s_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        i++;
        if (i < pl.size()) begin
          sif.s_data = pl[i];
          sif.s_last = (i == pl.size() - 1);
        end
      end
      budget++;
      if (budget > 300) begin
        chk("send_timeout", budget, 0);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    while ((busy || exp_q.size() != 0) && b < 600) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 600) chk("idle_timeout", b, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_en    = 1'b0;
        seen       = 1'b0;
        run        = 0;
        start_pend = 1'b0;
      end else begin
        if (start_pend) begin
          chk("start_en", gmii_tx_en, 1);
          chk("start_byte", gmii_txd, 8'h55);
        end
        start_pend = !busy && sif.s_valid;
        if (gmii_tx_en) begin
          if (!prev_en) begin
            if (seen) begin
              last_gap = run;
              chk("ifg_min", (run >= IFG), 1);
            end
            run = 0;
          end
          run++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_byte: got %h with no frame byte expected (t=%0t)", gmii_txd, $time);
          end else begin
            e = exp_q.pop_front();
            chk("txd", gmii_txd, e.d);
            chk("frame_done", frame_done, e.done);
            chk("underrun", underrun, e.ur);
          end
        end else begin
          if (prev_en) begin
            last_len = run;
            seen     = 1'b1;
            run      = 0;
          end
          run++;
          chk("idle_txd", gmii_txd, 0);
          chk("idle_pulses", {frame_done, underrun}, 0);
          chk("idle_ready", sif.s_ready, 0);
        end
        prev_en = gmii_tx_en;
      end
    end
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] pl2[$];
    int         elen, elen2, len, drop;
    bit         ur;

    for (int n = 0; n < 256; n++) begin
      logic [31:0] r;
      r = 32'(n);
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      crc_tbl[n] = r;
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    sif.s_data  = 8'h00;

    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1);
      end
    join_none

    #1 rst_n = 1'b0;
    #1;
    chk("reset_tx_en", gmii_tx_en, 0);
    chk("reset_txd", gmii_txd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {frame_done, underrun}, 0);
    chk("reset_ready", sif.s_ready, 0);

    pl.delete();
    for (int k = 0; k < 9; k++) pl.push_back(8'h31 + 8'(k));
    chk("model_crc_check_value", fcs_of(pl), 32'hCBF43926);

    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // "123456789"
    push_frame(pl, 9, 1'b0, elen);
    send(pl, -1, -1);
    wait_idle();
    chk("len_123456789", last_len, elen);

    // 14-byte payload (padded when the pad feature is built in)
    pl.delete();
    for (int k = 0; k < 14; k++) pl.push_back(8'($urandom));
    push_frame(pl, 14, 1'b0, elen);
    send(pl, -1, -1);
    wait_idle();
    chk("len_14", last_len, elen);

    // Back-to-back frames with s_valid held high
    pl.delete();
    pl2.delete();
    for (int k = 0; k < 10; k++) pl.push_back(8'($urandom));
    for (int k = 0; k < 7; k++) pl2.push_back(8'($urandom));
    push_frame(pl, 10, 1'b0, elen);
    send(pl, -1, -1);
    push_frame(pl2, 7, 1'b0, elen2);
    send(pl2, -1, -1);
    wait_idle();
    chk("b2b_gap", last_gap, IFG);
    chk("b2b_len2", last_len, elen2);

    // Underrun after 5 of 20 bytes, then a normal frame
    pl.delete();
    for (int k = 0; k < 20; k++) pl.push_back(8'($urandom));
    push_frame(pl, 5, 1'b1, elen);
    send(pl, 5, -1);
    wait_idle();
    chk("len_underrun", last_len, elen);
    pl2.delete();
    for (int k = 0; k < 20; k++) pl2.push_back(8'($urandom));
    push_frame(pl2, 20, 1'b0, elen);
    send(pl2, -1, -1);
    wait_idle();
    chk("len_after_underrun", last_len, elen);

    // Reset during DATA, next frame starts on the first clock after release
    push_frame(pl, 20, 1'b0, elen);
    send(pl, -1, 3);
    push_frame(pl2, 20, 1'b0, elen);
    send(pl2, -1, -1);
    wait_idle();
    chk("len_after_reset", last_len, elen);

    // 1-byte payload
    pl.delete();
    pl.push_back(8'hAB);
    push_frame(pl, 1, 1'b0, elen);
    send(pl, -1, -1);
    wait_idle();
    chk("len_1byte", last_len, elen);

    // Random frames, occasional underrun and back-to-back offering
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 80);
      ur  = (len > 1) && ($urandom_range(0, 5) == 0);
      drop = ur ? $urandom_range(1, len - 1) : -1;
      pl.delete();
      for (int k = 0; k < len; k++) pl.push_back(8'($urandom));
      push_frame(pl, ur ? drop : len, ur, elen);
      send(pl, drop, -1);
      if ($urandom_range(0, 2) != 0) begin
        wait_idle();
        chk("len_random", last_len, elen);
        for (int w = 0; w < $urandom_range(0, 3); w++) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_idle();
    chk("queue_drained", exp_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Ethernet MAC transmit framer on the GMII side of the RGMII bridge, in the gmii_tx_clk domain.
- Accepts a payload byte stream (destination MAC through end of payload) over a valid/ready/last handshake.
- Emits a complete GMII frame: preamble, SFD, payload, optional zero padding, CRC-32 FCS, then enforces the inter-frame gap.
- gmii_tx_en/gmii_txd drive the bridge's transmit inputs directly.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 preamble bytes before the SFD.
- IFG_BYTES, 12, idle cycles with gmii_tx_en low after each frame's last FCS byte.
- MIN_FRAME, 60, minimum payload+pad length in bytes (excludes FCS); used only with padding enabled.

Ports:
- gmii_tx_clk  input  1  GMII transmit clock, 125 MHz; sole clock.
- rst_n  input  1  Asynchronous active-low reset.
- s_data  input  8  Payload byte.
- s_valid  input  1  s_data valid.
- s_last  input  1  Marks the final payload byte.
- s_ready  output  1  Framer accepts a byte when s_valid && s_ready.
- gmii_tx_en  output  1  GMII transmit enable, registered.
- gmii_txd  output  8  GMII transmit data, registered.
- busy  output  1  High in every state except IDLE.
- frame_done  output  1  One-cycle pulse with the last FCS byte.
- underrun  output  1  One-cycle pulse when a frame is aborted by a mid-frame s_valid drop.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (gmii_tx_clk, rst_n).
- Reset values: all outputs 0; state IDLE; CRC register 0xFFFFFFFF; counters 0. Reset asserted mid-frame clears gmii_tx_en immediately, with no FCS and no IFG. A frame may start on the first clock after reset release.
- States: IDLE -> PREAMBLE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
- IDLE:
  - s_ready = 0.
  - s_valid sampled high at edge T: PREAMBLE_LEN bytes of 0x55 appear on gmii_txd from T+1 with gmii_tx_en = 1.
  - 0xD5 follows at T+1+PREAMBLE_LEN.
- s_ready:
  - Combinational, high in the SFD cycle and in DATA until the s_last byte is accepted.
  - The first payload byte appears on the wire immediately after 0xD5.
  - A byte accepted at edge n appears on gmii_txd at n+1.
- DATA:
  - Every accepted byte updates the CRC and increments an 11-bit byte counter that saturates at 2047. No maximum-length check.
  - Accepting s_last goes to PAD if padding is enabled and count < MIN_FRAME; otherwise goes to FCS.
- Underrun:
  - Triggered when s_valid is low in the SFD cycle or in a DATA cycle before s_last.
  - underrun pulses; the state goes to FCS and emits the bitwise inverse of the correct FCS, so the receiver discards the frame.
  - Upstream must not resume that frame; bytes offered during FCS/IFG are not accepted.
- PAD: emits 0x00 bytes, each included in the CRC, until count == MIN_FRAME.
- CRC and FCS:
  - Ethernet CRC-32, reflected poly 0x04C11DB7, init 0xFFFFFFFF.
  - FCS = ~crc, sent as 4 bytes, least-significant byte first.
  - frame_done pulses with the 4th FCS byte.
- IFG: gmii_tx_en = 0 and gmii_txd = 0 for exactly IFG_BYTES cycles, then IDLE. Back-to-back frames therefore have exactly IFG_BYTES idle cycles between them.
- Edge cases:
  - s_valid and s_last asserted on the first byte gives a legal 1-byte payload.
  - s_valid high during IFG is ignored.

Optional Feature:
- Macro: GMII_TX_PAD_EN.
- Defined: short payloads are zero-padded to MIN_FRAME bytes before the FCS.
- Undefined: no PAD state; FCS immediately follows the last payload byte for any length; MIN_FRAME unused.

Decomposition:
- Package eth_pkg holds:
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5;
  - CRC_POLY_REFL 32'hEDB88320, CRC_INIT 32'hFFFFFFFF;
  - the state enumeration.
- Sub-module eth_crc32_d8 holds:
  - the byte-parallel CRC-32 update with enable and synchronous init;
  - shared later with the receive-side frame checker.

Test Plan:
- PAD disabled, payload ASCII "123456789" (9 bytes, s_last on '9') -> wire shows 7x55, D5, 31..39, then FCS 26 39 F4 CB; frame_done pulses on CB; 21 tx_en cycles total.
- PAD enabled, 14-byte payload -> 46 bytes of 0x00 follow the payload, then 4 FCS bytes matching a reference model over 60 bytes; tx_en high for 72 cycles.
- Two frames offered back-to-back with s_valid held high -> exactly 12 cycles of gmii_tx_en low between them; s_ready low throughout the gap.
- s_valid dropped after payload byte 5 of 20 -> underrun pulses once, inverted FCS sent, then IFG, then IDLE; following frame transmits normally.
- rst_n pulsed low during DATA -> gmii_tx_en goes low asynchronously, busy = 0; next frame starts at the cycle after release with a full preamble.
- 1-byte payload 0xAB with s_valid and s_last together, PAD disabled -> 55x7, D5, AB, 4 FCS bytes matching the reference model, frame_done once.
